// File: rtl/note_mixer.sv
// note_mixer
//   Mixes the twelve per-note oscillators into one 8-bit sample. On each
//   accepted sample request the held-key mask is snapshotted, every note is
//   visited once (square level from its live count against half its limit),
//   and the mean level of the held notes is computed with a 12-step
//   restoring divider. Latency from acceptance to the valid pulse is fixed
//   at 24 cycles regardless of the key pattern.
//
// Ports
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   count_in      live oscillator counts, note k at [BITLEN*k +: BITLEN]
//   lim_in        per-note wrap limits, same packing
//   keys          held-key mask, bit k = note k
//   sample_req    request strobe from the output stage
//   sample        last computed mixed sample (holds between updates)
//   sample_valid  one-cycle pulse when sample has just been updated
//   busy          high while a request is being processed
//   state_dbg     current FSM state (IDLE=0, ACC=1, DIV=2, DONE=3)
//
// Handshake: sample_req is sampled only in IDLE; a request seen in any
// other state is dropped, not queued. sample_valid is a single-cycle pulse
// with no back-pressure; the consumer must take sample while it is high or
// any time before the next valid pulse.

module note_mixer #(
  parameter int BITLEN = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [12*BITLEN-1:0] count_in,
  input  logic [12*BITLEN-1:0] lim_in,
  input  logic [11:0]          keys,
  input  logic                 sample_req,
  output logic [7:0]           sample,
  output logic                 sample_valid,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] key_q,   key_d;
  logic [11:0] sum_q,   sum_d;
  logic [3:0]  n_q,     n_d;
  logic [3:0]  ch_q,    ch_d;     // channel index in ACC, iteration index in DIV
  logic [11:0] quot_q,  quot_d;   // dividend shifts out the top, quotient in the bottom
  logic [12:0] rem_q,   rem_d;
  logic [7:0]  sample_q, sample_d;
  logic        valid_q,  valid_d;

  // Channel selected by ch_q; counts are taken live at the ACC edge.
  logic [BITLEN-1:0] cnt_sel;
  logic [BITLEN-1:0] lim_sel;
  logic              key_sel;
  logic              ch_high;

  always_comb begin
    cnt_sel = '0;
    lim_sel = '0;
    key_sel = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (ch_q == 4'(k)) begin
        cnt_sel = count_in[BITLEN*k +: BITLEN];
        lim_sel = lim_in[BITLEN*k +: BITLEN];
        key_sel = key_q[k];
      end
    end
    // A count beyond the limit (after a limit change) simply reads as low.
    ch_high = key_sel && (cnt_sel <= (lim_sel >> 1));
  end

  // One restoring-division step: bring down the next dividend bit and
  // subtract the divisor when it fits.
  logic [12:0] rem_shift;
  logic [12:0] rem_step;
  logic [11:0] quot_step;
  logic [12:0] n_ext;

  always_comb begin
    n_ext     = {9'd0, n_q};
    rem_shift = {rem_q[11:0], quot_q[11]};
    if (rem_shift >= n_ext) begin
      rem_step  = rem_shift - n_ext;
      quot_step = {quot_q[10:0], 1'b1};
    end else begin
      rem_step  = rem_shift;
      quot_step = {quot_q[10:0], 1'b0};
    end
  end

  logic [11:0] sum_acc;
  logic [3:0]  n_acc;

  always_comb begin
    sum_acc  = sum_q + (ch_high ? 12'd255 : 12'd0);
    n_acc    = n_q + {3'd0, key_sel};

    state_d  = state_q;
    key_d    = key_q;
    sum_d    = sum_q;
    n_d      = n_q;
    ch_d     = ch_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    sample_d = sample_q;
    valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sample_req) begin
          key_d   = keys;
          sum_d   = '0;
          n_d     = '0;
          ch_d    = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        sum_d = sum_acc;
        n_d   = n_acc;
        if (ch_q == 4'd11) begin
          // Load the final sum straight into the divider.
          quot_d  = sum_acc;
          rem_d   = '0;
          ch_d    = '0;
          state_d = DIV;
        end else begin
          ch_d = ch_q + 4'd1;
        end
      end
      DIV: begin
        quot_d = quot_step;
        rem_d  = rem_step;
        if (ch_q == 4'd11) begin
          // With no held keys the divider runs against zero; discard it.
          sample_d = (n_q == 4'd0) ? 8'd0 : quot_step[7:0];
          valid_d  = 1'b1;
          ch_d     = '0;
          state_d  = DONE;
        end else begin
          ch_d = ch_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      key_q    <= '0;
      sum_q    <= '0;
      n_q      <= '0;
      ch_q     <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      sum_q    <= sum_d;
      n_q      <= n_d;
      ch_q     <= ch_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_note_mixer.sv
module tb_note_mixer;

  localparam int BITLEN = 16;
  localparam int W      = 12 * BITLEN;

  logic         clk;
  logic         n_rst;
  logic [W-1:0] count_in;
  logic [W-1:0] lim_in;
  logic [11:0]  keys;
  logic         sample_req;
  logic [7:0]   sample;
  logic         sample_valid;
  logic         busy;
  logic [1:0]   state_dbg;

  note_mixer #(.BITLEN(BITLEN)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .count_in     (count_in),
    .lim_in       (lim_in),
    .keys         (keys),
    .sample_req   (sample_req),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int acc_q[$];
  int valid_cnt = 0;
  int last_acc  = 0;
  logic busy_prev  = 1'b0;
  logic valid_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (n_rst) begin
      if (busy && !busy_prev) begin
        acc_q.push_back(cyc);
        last_acc = cyc;
      end
      if (sample_valid) begin
        valid_cnt++;
        check("valid_single_cycle", {31'd0, valid_prev}, 32'd0);
        check("latency", cyc - last_acc, 24);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          check("sample", {24'd0, sample}, {24'd0, exp_q.pop_front()});
        end
      end
      busy_prev  = busy;
      valid_prev = sample_valid;
    end else begin
      busy_prev  = 1'b0;
      valid_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valids(input int v0, input int n, input string nm);
    for (int i = 0; i < 40 * n && (valid_cnt - v0) < n; i++) tick();
    check(nm, valid_cnt - v0, n);
  endtask

  task automatic run_vec(input logic [11:0] k, input logic [W-1:0] c,
                         input logic [W-1:0] l, input logic [7:0] e);
    int v0;
    tick();
    keys = k; count_in = c; lim_in = l; sample_req = 1'b1;
    exp_q.push_back(e);
    v0 = valid_cnt;
    tick();
    sample_req = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_valids(v0, 1, "valid_count");
    tick();
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  // Reference: mean square level of held keys, floored.
  function automatic logic [7:0] model(input logic [11:0] k, input logic [W-1:0] c,
                                       input logic [W-1:0] l);
    int s = 0;
    int n = 0;
    for (int i = 0; i < 12; i++) begin
      if (k[i]) begin
        n++;
        if (c[BITLEN*i +: BITLEN] <= l[BITLEN*i +: BITLEN] / 2) s += 255;
      end
    end
    return (n == 0) ? 8'd0 : 8'(s / n);
  endfunction

  function automatic logic [W-1:0] fill(input logic [BITLEN-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < 12; i++) r[BITLEN*i +: BITLEN] = v;
    return r;
  endfunction

  // live-read scenario on note D (index 2): count switches at negedge index at_n
  task automatic live(input logic [15:0] c_init, input logic [15:0] c_new,
                      input int at_n, input logic [7:0] e);
    int v0;
    tick();
    keys = 12'h004; lim_in = fill(16'd100); count_in = fill(16'd0);
    count_in[BITLEN*2 +: BITLEN] = c_init;
    sample_req = 1'b1;
    exp_q.push_back(e);
    v0 = valid_cnt;
    tick();                       // just after E0
    sample_req = 1'b0;
    for (int i = 0; i < at_n; i++) tick();
    count_in[BITLEN*2 +: BITLEN] = c_new;
    wait_valids(v0, 1, "live_valid_count");
    tick();
  endtask

  typedef struct {
    logic [11:0]  k;
    logic [W-1:0] c;
    logic [W-1:0] l;
    logic [7:0]   e;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int v0;
    int a0;
    n_rst = 1'b0; sample_req = 1'b0; keys = '0; count_in = '0; lim_in = '0;

    // vector table: expected values worked out by hand
    for (int i = 0; i < 12; i++) begin
      vecs[i].c = fill(16'd0);
      vecs[i].l = fill(16'd100);
    end
    vecs[0].k = 12'h001; vecs[0].c[0 +: 16] = 16'd50; vecs[0].e = 8'd255;
    vecs[1].k = 12'h001; vecs[1].c[0 +: 16] = 16'd51; vecs[1].e = 8'd0;
    vecs[2].k = 12'h007; vecs[2].c[0 +: 16] = 16'd10; vecs[2].c[16 +: 16] = 16'd50;
    vecs[2].c[32 +: 16] = 16'd51; vecs[2].e = 8'd170;
    vecs[3].k = 12'h000; vecs[3].e = 8'd0;
    vecs[4].k = 12'hFFF; vecs[4].e = 8'd255;
    vecs[5].k = 12'h020; vecs[5].l = fill(16'd0); vecs[5].e = 8'd255;
    vecs[6].k = 12'hFFF; for (int i = 5; i < 12; i++) vecs[6].c[16*i +: 16] = 16'd90;
    vecs[6].e = 8'd106;
    vecs[7].k = 12'h003; vecs[7].c[0 +: 16] = 16'd150; vecs[7].e = 8'd127;
    vecs[8].k = 12'h010; vecs[8].l = fill(16'd1); vecs[8].e = 8'd255;
    vecs[9].k = 12'h010; vecs[9].l = fill(16'd1); vecs[9].c = fill(16'd1); vecs[9].e = 8'd0;
    vecs[10].k = 12'h801; vecs[10].l = fill(16'hFFFF); vecs[10].c[0 +: 16] = 16'h7FFF;
    vecs[10].c[176 +: 16] = 16'hFFFF; vecs[10].e = 8'd127;
    vecs[11].k = 12'h0F0; vecs[11].c[112 +: 16] = 16'd99; vecs[11].e = 8'd191;

    // reset state
    #12;
    check("rst_sample", {24'd0, sample}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    tick();
    n_rst = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i].k, vecs[i].c, vecs[i].l, vecs[i].e);

    // random vectors against the reference model
    for (int i = 0; i < 8; i++) begin
      logic [11:0]  rk;
      logic [W-1:0] rc;
      logic [W-1:0] rl;
      rk = 12'($urandom_range(0, 4095));
      for (int j = 0; j < 12; j++) begin
        rl[BITLEN*j +: BITLEN] = 16'($urandom_range(0, 300));
        rc[BITLEN*j +: BITLEN] = 16'($urandom_range(0, 310));
      end
      run_vec(rk, rc, rl, model(rk, rc, rl));
    end

    // live read of note D
    live(16'd200, 16'd10, 1, 8'd255);
    live(16'd10, 16'd200, 2, 8'd0);
    live(16'd10, 16'd200, 3, 8'd255);

    // requests during busy are dropped
    tick();
    keys = 12'h001; count_in = fill(16'd0); lim_in = fill(16'd100); sample_req = 1'b1;
    exp_q.push_back(8'd255);
    v0 = valid_cnt; a0 = acc_q.size();
    tick();                                // N0
    sample_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();    // N4
    sample_req = 1'b1;
    tick();                                // N5
    sample_req = 1'b0;
    for (int i = 0; i < 19; i++) tick();   // N24
    sample_req = 1'b1;
    tick();                                // N25
    sample_req = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("busy_ignore_valids", valid_cnt - v0, 1);
    check("busy_ignore_accepts", acc_q.size() - a0, 1);
    check("busy_ignore_idle", {31'd0, busy}, 32'd0);

    // held request re-accepted every 26 cycles
    acc_q.delete();
    tick();
    keys = 12'h007; count_in = fill(16'd0); count_in[32 +: 16] = 16'd51; sample_req = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(8'd170);
    v0 = valid_cnt;
    for (int i = 0; i < 120 && acc_q.size() < 3; i++) tick();
    sample_req = 1'b0;
    check("hold_accepts", acc_q.size(), 3);
    wait_valids(v0, 3, "hold_valids");
    if (acc_q.size() >= 3) begin
      check("hold_gap1", acc_q[1] - acc_q[0], 26);
      check("hold_gap2", acc_q[2] - acc_q[1], 26);
    end
    tick();

    // reset mid-divide after a 255 result
    run_vec(12'h001, fill(16'd0), fill(16'd100), 8'd255);
    tick();
    keys = 12'h001; sample_req = 1'b1;
    exp_q.push_back(8'd255);
    tick();
    sample_req = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("pre_rst_state_div", {30'd0, state_dbg}, 32'd2);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_sample", {24'd0, sample}, 32'd0);
    check("async_rst_valid", {31'd0, sample_valid}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    n_rst = 1'b1;
    v0 = valid_cnt;
    for (int i = 0; i < 40; i++) tick();
    check("no_valid_after_rst", valid_cnt - v0, 0);
    check("idle_after_rst", {31'd0, busy}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/note_mixer.md
# note_mixer

Consumer of the twelve per-note oscillator counters. On each sample request it scans the twelve notes and derives a square-wave level for each held key from that note's live count and limit. It then outputs the mean level of the held keys as an 8-bit sample. It sits between the oscillator bank and the audio output stage (PWM/DAC), and is paced by that stage's sample strobe.

## Interface
- BITLEN, 16, width of each note's count and limit.
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  reset, asynchronous, active-low.
- count_in  input  12*BITLEN  live oscillator counts; note k (0=C … 11=B) at [BITLEN*k +: BITLEN].
- lim_in  input  12*BITLEN  per-note wrap limits, same packing; counter runs 0..lim.
- keys  input  12  held-key mask, bit k = note k.
- sample_req  input  1  request strobe from the output stage.
- sample  output  8  last computed mixed sample.
- sample_valid  output  1  one-cycle pulse: new sample available.
- busy  output  1  high while a request is in progress.

## Operation
- FSM states: IDLE, ACC, DIV, DONE. busy = (state != IDLE).
- IDLE: if sample_req is high at an edge:
  - snapshot keys into key_q;
  - clear sum (12 bits) and n (4 bits);
  - ch=0; go to ACC.
  - sample_req in any other state is ignored; no queuing.
- ACC, one channel per edge, ch = 0..11. Channel k is high when key_q[k] and count_k <= (lim_k >> 1), unsigned compare, counts read live at that edge.
  - If key_q[k]: n += 1.
  - If channel k is high: sum += 255.
  - After ch 11: go to DIV.
- DIV: 12-iteration restoring divide, sum / n, one bit per edge, MSB first; floor result. Width rules:
  - sum max 3060, fits 12 bits;
  - n is 1..12;
  - quotient ≤ 255, so the low 8 bits are the result.
  - n==0: result forced to 0; DIV still takes 12 cycles.
  - On the final DIV edge, sample <= result; state goes to DONE.
- DONE: sample_valid high for this cycle; next edge goes to IDLE.
- sample holds its value between updates.
- Count > lim (transient after a limit change) is treated as low; no special handling.
- lim=0: count 0 compares ≤ 0, so the channel is high.
- Reset (async, any state): state=IDLE, sample=0, sample_valid=0, busy=0, internal sum/n/ch/quotient=0. A request in flight is discarded with no valid pulse.

## Timing
- Request accepted at edge E0 (state IDLE, sample_req=1).
- E1..E12: channels 0..11 accumulated.
- E13..E24: divide iterations; sample updated at E24.
- sample_valid high from E24 to E25.
- busy high from E0 to E25.
- Fixed latency, independent of keys:
  - E0 to valid pulse = 24 cycles;
  - earliest next acceptance E26, so max request rate is 1 per 26 cycles.
- A request held high continuously is re-accepted every 26 cycles.
- The output stage strobe (≫26 cycles apart) never collides in normal use.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset: drive n_rst low mid-DIV → sample=0, sample_valid=0, busy=0 immediately (asynchronous). After release, no valid pulse until a new request.
- Single key: keys=0x001, lim_C=100, count_C=50 → valid pulse 24 cycles after acceptance, sample=255. With count_C=51 → sample=0.
- Mean with floor: keys=0x007, channels 0 and 1 high, channel 2 low (count>lim>>1) → sum=510, n=3, sample=170.
- Edge cases:
  - keys=0 → sample=0 with normal latency.
  - keys=0xFFF, all counts 0 → sample=255.
  - lim=0, count=0 on one held key → 255.
- Busy handling: pulse sample_req at E5 and E25 after an accepted request → both ignored, exactly one valid pulse. Hold sample_req high → acceptances at E0, E26, E52.
- Live read: change count_D between E0 and E3 → the value present at E3 (channel 2 edge) decides channel D.
